// File: rtl/mii_rx_fsm_pkg.sv
// rtl/mii_rx_fsm_pkg.sv - shared state encodings, nibble codes and ctrl-block field offsets
package mii_rx_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_DROP = 3'd3,
        ST_DONE = 3'd4
    } rx_state_e;

    localparam logic [3:0] PRE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE = 4'hD;

    localparam int SEQ_MSB = 23;
    localparam int SEQ_LSB = 12;
    localparam int ERR_BIT = 11;
    localparam int LEN_MSB = 10;

endpackage

// File: rtl/rx_nibble_packer.sv
// rtl/rx_nibble_packer.sv - pairs low/high nibbles into a registered byte with a one-cycle strobe
module rx_nibble_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       nib_valid,
    input  logic       clear,
    input  logic [3:0] nib,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       phase
);

    logic       phase_q, phase_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_valid_q, byte_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= 1'b0;
            lo_q         <= 4'h0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            lo_q         <= lo_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    // byte_q is deliberately left alone on clear so the last byte stays visible
    always_comb begin
        phase_d      = phase_q;
        lo_d         = lo_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        if (clear) begin
            phase_d = 1'b0;
        end else if (nib_valid) begin
            if (!phase_q) begin
                lo_d    = nib;
                phase_d = 1'b1;
            end else begin
                byte_d       = {nib, lo_q};
                byte_valid_d = 1'b1;
                phase_d      = 1'b0;
            end
        end
    end

    assign byte_data  = byte_q;
    assign byte_valid = byte_valid_q;
    assign phase      = phase_q;

endmodule

// File: rtl/mii_rx_fsm.sv
// rtl/mii_rx_fsm.sv - MII nibble receiver: preamble/SFD strip, byte assembly, per-frame ctrl block
module mii_rx_fsm
    import mii_rx_fsm_pkg::*;
#(
    parameter int MIN_PRE = 7,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_phy,
    input  logic        reset,
    input  logic        rx_dv_in,
    input  logic [3:0]  data_in,
    output logic [7:0]  data_out,
    output logic        wren_data_out,
    output logic [23:0] ctrl_block_out,
    output logic        wren_ctrl_out,
    output logic [11:0] frame_seq_out,
    output logic        rcv_done_out
);

    localparam logic [3:0]  MIN_PRE_L = 4'(MIN_PRE);
    localparam logic [10:0] MIN_LEN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    rx_state_e   state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [10:0] len_q, len_d;
    logic        err_q, err_d;
    logic        started_q, started_d;
    logic [11:0] seq_q, seq_d;
    logic [23:0] ctrl_q, ctrl_d;
    logic        done_q, done_d;

    logic        nib_valid;
    logic        pk_clear;
    logic        pk_phase;
    logic [7:0]  pk_byte;
    logic        pk_byte_valid;

    rx_nibble_packer u_packer (
        .clk        (clk_phy),
        .rst        (reset),
        .nib_valid  (nib_valid),
        .clear      (pk_clear),
        .nib        (data_in),
        .byte_data  (pk_byte),
        .byte_valid (pk_byte_valid),
        .phase      (pk_phase)
    );

    always_ff @(posedge clk_phy or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pre_cnt_q <= 4'd0;
            len_q     <= 11'd0;
            err_q     <= 1'b0;
            started_q <= 1'b0;
            seq_q     <= 12'd0;
            ctrl_q    <= 24'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            started_q <= started_d;
            seq_q     <= seq_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        started_d = started_q;
        seq_d     = seq_q;
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        nib_valid = 1'b0;
        pk_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv_in) begin
                    if (data_in == PRE_NIBBLE) begin
                        state_d   = ST_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d   = ST_DROP;
                        started_d = 1'b0;
                    end
                end
            end
            ST_PRE: begin
                if (!rx_dv_in) begin
                    state_d = ST_IDLE;
                end else if (data_in == PRE_NIBBLE) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (data_in == SFD_NIBBLE && pre_cnt_q >= MIN_PRE_L) begin
                    state_d   = ST_DATA;
                    len_d     = 11'd0;
                    err_d     = 1'b0;
                    started_d = 1'b1;
                    pk_clear  = 1'b1;
                end else begin
                    state_d   = ST_DROP;
                    started_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (!rx_dv_in) begin
                    state_d = ST_DONE;
                    if (pk_phase || len_q < MIN_LEN_L) err_d = 1'b1;
                end else if (pk_phase) begin
                    // an over-long frame is truncated at MAX_LEN and drained in DROP
                    if (len_q == MAX_LEN_L) begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        nib_valid = 1'b1;
                        len_d     = len_q + 11'd1;
                    end
                end else begin
                    nib_valid = 1'b1;
                end
            end
            ST_DROP: begin
                if (!rx_dv_in) state_d = started_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                ctrl_d[SEQ_MSB:SEQ_LSB] = seq_q;
                ctrl_d[ERR_BIT]         = err_q;
                ctrl_d[LEN_MSB:0]       = len_q;
                done_d                  = 1'b1;
                seq_d                   = seq_q + 12'd1;
                started_d               = 1'b0;
                state_d                 = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_out       = pk_byte;
    assign wren_data_out  = pk_byte_valid;
    assign ctrl_block_out = ctrl_q;
    assign wren_ctrl_out  = done_q;
    assign rcv_done_out   = done_q;
    assign frame_seq_out  = seq_q;

endmodule

// File: tb/tb_mii_rx_fsm.sv
// tb/tb_mii_rx_fsm.sv - randomized self-checking bench for mii_rx_fsm against a frame-level model
module tb_mii_rx_fsm;

    localparam int MIN_PRE = 7;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [3:0]  rx_nib = 4'h0;
    logic [7:0]  data_out;
    logic        wren_data_out;
    logic [23:0] ctrl_block_out;
    logic        wren_ctrl_out;
    logic [11:0] frame_seq_out;
    logic        rcv_done_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  drv_nibs[$];
    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_ctrl[$];
    logic [11:0] model_seq = 12'd0;

    logic [7:0]  mon_bytes[$];
    logic [23:0] mon_ctrl[$];
    int          mon_done = 0;

    mii_rx_fsm dut (
        .clk_phy        (clk),
        .reset          (rst),
        .rx_dv_in       (rx_dv),
        .data_in        (rx_nib),
        .data_out       (data_out),
        .wren_data_out  (wren_data_out),
        .ctrl_block_out (ctrl_block_out),
        .wren_ctrl_out  (wren_ctrl_out),
        .frame_seq_out  (frame_seq_out),
        .rcv_done_out   (rcv_done_out)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (wren_data_out) mon_bytes.push_back(data_out);
            if (wren_ctrl_out) mon_ctrl.push_back(ctrl_block_out);
            if (rcv_done_out) mon_done++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level rules: leading 5s, then D with enough preamble, then nibble pairs lo-first.
    task automatic model_frame();
        int i, p, d, len;
        logic err;
        logic [10:0] len11;
        exp_bytes.delete();
        exp_ctrl.delete();
        i = 0;
        p = 0;
        while (i < drv_nibs.size() && drv_nibs[i] == 4'h5) begin
            p++;
            i++;
        end
        if (p == 0 || i >= drv_nibs.size()) return;
        if (drv_nibs[i] != 4'hD || p < MIN_PRE) return;
        i++;
        d   = drv_nibs.size() - i;
        len = d / 2;
        err = (d % 2 != 0) || (len < MIN_LEN);
        if (len > MAX_LEN) begin
            len = MAX_LEN;
            err = 1'b1;
        end
        for (int k = 0; k < len; k++)
            exp_bytes.push_back({drv_nibs[i + 2*k + 1], drv_nibs[i + 2*k]});
        len11 = 11'(len);
        exp_ctrl.push_back({model_seq, err, len11});
        model_seq = model_seq + 12'd1;
    endtask

    task automatic build(input int npre, input logic [3:0] sfd, input int ndata, input bit incr);
        logic [7:0] b;
        drv_nibs.delete();
        repeat (npre) drv_nibs.push_back(4'h5);
        drv_nibs.push_back(sfd);
        for (int j = 0; j < ndata; j++) begin
            if (incr) begin
                b = 8'(j / 2);
                drv_nibs.push_back((j % 2) ? b[7:4] : b[3:0]);
            end else begin
                drv_nibs.push_back(4'($urandom));
            end
        end
    endtask

    task automatic run_frame(input string tag);
        int nb;
        model_frame();
        mon_bytes.delete();
        mon_ctrl.delete();
        mon_done = 0;
        foreach (drv_nibs[i]) begin
            @(negedge clk);
            rx_dv  = 1'b1;
            rx_nib = drv_nibs[i];
        end
        @(negedge clk);
        rx_dv  = 1'b0;
        rx_nib = 4'($urandom);
        repeat (3) @(negedge clk);
        #1;
        check_eq({tag, "_nbytes"}, 32'(mon_bytes.size()), 32'(exp_bytes.size()));
        nb = (mon_bytes.size() < exp_bytes.size()) ? mon_bytes.size() : exp_bytes.size();
        for (int k = 0; k < nb; k++)
            check_eq($sformatf("%s_byte%0d", tag, k), 32'(mon_bytes[k]), 32'(exp_bytes[k]));
        check_eq({tag, "_nctrl"}, 32'(mon_ctrl.size()), 32'(exp_ctrl.size()));
        if (mon_ctrl.size() == 1 && exp_ctrl.size() == 1)
            check_eq({tag, "_ctrl"}, 32'(mon_ctrl[0]), 32'(exp_ctrl[0]));
        check_eq({tag, "_done"}, 32'(mon_done), 32'(exp_ctrl.size()));
        check_eq({tag, "_seq"}, 32'(frame_seq_out), 32'(model_seq));
    endtask

    initial begin
        rst = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("rst_data", 32'(data_out), 32'h0);
        check_eq("rst_wren_data", 32'(wren_data_out), 32'h0);
        check_eq("rst_ctrl", 32'(ctrl_block_out), 32'h0);
        check_eq("rst_wren_ctrl", 32'(wren_ctrl_out), 32'h0);
        check_eq("rst_seq", 32'(frame_seq_out), 32'h0);
        check_eq("rst_done", 32'(rcv_done_out), 32'h0);

        build(15, 4'hD, 128, 1'b1);
        run_frame("good0");
        check_eq("good0_lit", 32'(ctrl_block_out), 32'h000040);
        run_frame("good1");
        check_eq("good1_lit", 32'(ctrl_block_out), 32'h001040);

        build(3, 4'hA, 0, 1'b0);
        run_frame("bad_sfd");
        build(4, 4'hD, 128, 1'b1);
        run_frame("short_pre");
        build(7, 4'hD, 128, 1'b0);
        run_frame("good2");

        build(7, 4'hD, 20, 1'b0);
        run_frame("runt");
        build(7, 4'hD, 129, 1'b0);
        run_frame("odd");
        build(8, 4'hD, 3040, 1'b0);
        run_frame("long");
        check_eq("long_len", 32'(ctrl_block_out[11:0]), 32'hDEE);

        // asynchronous reset in the middle of byte 20
        build(7, 4'hD, 128, 1'b1);
        for (int i = 0; i < 47; i++) begin
            @(negedge clk);
            rx_dv  = 1'b1;
            rx_nib = drv_nibs[i];
        end
        #5;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_data", 32'(data_out), 32'h0);
        check_eq("mid_rst_ctrl", 32'(ctrl_block_out), 32'h0);
        check_eq("mid_rst_seq", 32'(frame_seq_out), 32'h0);
        rx_nib = 4'hA;
        repeat (3) @(negedge clk);
        mon_bytes.delete();
        mon_ctrl.delete();
        mon_done = 0;
        rst = 1'b0;
        model_seq = 12'd0;
        repeat (20) @(negedge clk);
        rx_dv = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_eq("post_rst_nbytes", 32'(mon_bytes.size()), 32'h0);
        check_eq("post_rst_nctrl", 32'(mon_ctrl.size()), 32'h0);
        check_eq("post_rst_seq", 32'(frame_seq_out), 32'h0);

        for (int f = 0; f < 4097; f++) begin
            build(MIN_PRE, 4'hD, 0, 1'b0);
            run_frame($sformatf("wrap%0d", f));
        end
        check_eq("wrap_seq_lit", 32'(frame_seq_out), 32'h1);

        for (int f = 0; f < 25; f++) begin
            int       npre;
            logic [3:0] sfd;
            npre = $urandom_range(0, 12);
            sfd  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hD;
            build(npre, sfd, $urandom_range(0, 180), 1'b0);
            run_frame($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
